turbo_rx_deframer: RTL
======================

# turbo_rx_deframer

Receive-side counterpart of the serial turbo encoder. Accepts one 3456-bit encoded frame on a single serial lane and unpacks it into systematic, tail and parity fields. It re-runs constituent encoder 1 over the recovered systematic bits and compares the result against the received parity-1 section. It reports the recovered 1148-bit MSD+CRC word together with a parity-consistency verdict, and sits at the front of the link-loopback and decoder-test datapath.

## Interface
Parameters:
- None. Frame geometry is fixed: 1148 systematic bits, 3+3 tail bits, 1148+3 parity-1 bits, 1148+3 parity-2 bits.

Ports:
- clk — in, 1 — single clock; all logic on rising edge.
- rst — in, 1 — reset; synchronous, active-high.
- start — in, 1 — pulse coincident with frame bit 0.
- in_TE_data — in, 1 — serial encoded frame, one bit per cycle.
- busy — out, 1 — high from the cycle after an accepted start until the done pulse.
- done — out, 1 — one-cycle pulse; result outputs are valid from this cycle on.
- MSD_CRC — out, 1148 — recovered systematic word; bit i = i-th received bit.
- p1_err — out, 1 — at least one parity-1 mismatch.
- err_cnt — out, 11 — number of parity-1 mismatches (see Configuration).

## Operation
- Frame order (bit 0 first): sys[0..1147], tail1[0..2], tail2[0..2], par1[0..1147], ptail1[0..2], par2[0..1147], ptail2[0..2].
- FSM states: IDLE, RECV, CHECK, DONE.
- IDLE: start=1 moves to RECV. The bit on in_TE_data in that same cycle is captured as frame bit 0.
- RECV: a 12-bit counter steps 0..3455.
  - Bits 0..1147 go to the sys register.
  - Bits 1154..2301 go to the par1 register; par1[j] = j-th bit of that section.
  - Tail, ptail and parity-2 bits are counted and discarded.
  - At count 3455 the FSM moves to CHECK.
- CHECK: an 11-bit counter k steps 0..1147 through the RSC re-encoder. The re-encoder has a 3-bit state s, cleared on CHECK entry.
  - Input u = sys[k].
  - Feedback f = s[2]^s[1]^u.
  - Parity p = s[2]^s[1]^s[0]^u.
  - Next state s <= {s[1], s[0], f}.
  - Mismatch when p != par1[1147-k], because the encoder emits parity bits in reverse order.
  - Each mismatch sets p1_err and increments err_cnt. err_cnt saturates at 2047.
  - At k=1147 the FSM moves to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Output registers: MSD_CRC, p1_err and err_cnt hold their values until the next accepted start. On an accepted start, p1_err and err_cnt clear; MSD_CRC updates as bits arrive.
- start outside IDLE (RECV, CHECK or DONE) is ignored, with no effect on the frame in progress.
- The stored sys bits are not modified during CHECK.

## Timing
- Reset values: busy=0, done=0, MSD_CRC=0, p1_err=0, err_cnt=0, FSM=IDLE, all counters 0.
- Start accepted at cycle 0 → busy=1 from cycle 1 → last frame bit at cycle 3455.
- CHECK runs cycles 3456..4603.
- done=1 at cycle 4604; busy=0 at cycle 4604.
- Earliest next accepted start is cycle 4605.
- rst asserted mid-RECV or mid-CHECK: the next edge forces reset values and aborts the frame. No done is issued for the aborted frame.
- rst and start in the same cycle: rst wins.

## Configuration
- TURBO_RX_ERR_CNT_EN defined: the 11-bit saturating mismatch counter is built, and err_cnt reports the count.
- TURBO_RX_ERR_CNT_EN undefined: the counter is not built and err_cnt is tied to 0. p1_err and all other behaviour are unchanged.

## Test plan
- All-zero 3456-bit frame, start at cycle 0 → done at cycle 4604, MSD_CRC=0, p1_err=0, err_cnt=0.
- Frame with sys = 1148'h…A5A5 pattern and par1 from the reference RSC model → MSD_CRC equals the pattern, p1_err=0, err_cnt=0.
- Same frame with par1[0] inverted → p1_err=1, err_cnt=1. With TURBO_RX_ERR_CNT_EN undefined → p1_err=1, err_cnt=0.
- All-zero frame with par1[0..1147] all ones → err_cnt=1148, p1_err=1.
- start re-pulsed at cycle 100 and at cycle 4000 → ignored; single done at cycle 4604.
- rst at cycle 2000 → reset values at cycle 2001, no done. A new start at cycle 2010 → done at cycle 6614.

Source files
------------

// File: rtl/turbo_rx_deframer_if.sv
// rtl/turbo_rx_deframer_if.sv - frame input and result bundle for turbo_rx_deframer
interface turbo_rx_deframer_if;
  logic          start;
  logic          in_TE_data;
  logic          busy;
  logic          done;
  logic [1147:0] MSD_CRC;
  logic          p1_err;
  logic [10:0]   err_cnt;

  // Frame source side: drives start and serial data, observes results.
  modport master (
    output start, in_TE_data,
    input  busy, done, MSD_CRC, p1_err, err_cnt
  );

  // Deframer side.
  modport slave (
    input  start, in_TE_data,
    output busy, done, MSD_CRC, p1_err, err_cnt
  );
endinterface

// File: rtl/turbo_rx_deframer.sv
// rtl/turbo_rx_deframer.sv - serial turbo frame unpacker with parity-1 re-encode check (optional TURBO_RX_ERR_CNT_EN)
module turbo_rx_deframer (
  input  logic                  clk,
  input  logic                  rst,
  turbo_rx_deframer_if.slave    bus
);

  localparam logic [11:0] LAST_BIT   = 12'd3455;
  localparam logic [11:0] SYS_END    = 12'd1148;
  localparam logic [11:0] PAR1_FIRST = 12'd1154;
  localparam logic [11:0] PAR1_LAST  = 12'd2301;
  localparam logic [10:0] LAST_K     = 11'd1147;

  typedef enum logic [1:0] {IDLE, RECV, CHECK, DONE} state_t;

  state_t        state_q, state_d;
  logic [11:0]   cnt_q;
  logic [10:0]   k_q;
  logic [2:0]    s_q;
  logic [1147:0] sys_q;
  logic [1147:0] par1_q;
  logic          p1_err_q;

  logic [10:0]   par_idx;
  logic          u, fb, par, mismatch;

  // par1 section offset; the 11-bit wrap is exact because the result is always < 1148.
  assign par_idx  = cnt_q[10:0] - 11'd1154;

  // RSC constituent-1 re-encoder step; received parity is stored in reverse order.
  assign u        = sys_q[k_q];
  assign fb       = s_q[2] ^ s_q[1] ^ u;
  assign par      = s_q[2] ^ s_q[1] ^ s_q[0] ^ u;
  assign mismatch = par ^ par1_q[LAST_K - k_q];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)         state_d = RECV;
      RECV:    if (cnt_q == LAST_BIT) state_d = CHECK;
      CHECK:   if (k_q == LAST_K)     state_d = DONE;
      DONE:                           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Frame capture and parity-check datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      k_q      <= '0;
      s_q      <= '0;
      sys_q    <= '0;
      par1_q   <= '0;
      p1_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sys_q[0] <= bus.in_TE_data;
            cnt_q    <= 12'd1;
            p1_err_q <= 1'b0;
          end
        end
        RECV: begin
          if (cnt_q < SYS_END)
            sys_q[cnt_q[10:0]] <= bus.in_TE_data;
          else if (cnt_q >= PAR1_FIRST && cnt_q <= PAR1_LAST)
            par1_q[par_idx] <= bus.in_TE_data;
          if (cnt_q == LAST_BIT) begin
            cnt_q <= '0;
            k_q   <= '0;
            s_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        CHECK: begin
          s_q <= {s_q[1], s_q[0], fb};
          if (mismatch) p1_err_q <= 1'b1;
          if (k_q == LAST_K) k_q <= '0;
          else               k_q <= k_q + 11'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef TURBO_RX_ERR_CNT_EN
  logic [10:0] err_cnt_q;

  // Saturating mismatch counter, cleared on each accepted start.
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_q <= '0;
    else if (state_q == IDLE && bus.start)
      err_cnt_q <= '0;
    else if (state_q == CHECK && mismatch && err_cnt_q != 11'h7FF)
      err_cnt_q <= err_cnt_q + 11'd1;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.busy    = (state_q == RECV) || (state_q == CHECK);
  assign bus.done    = (state_q == DONE);
  assign bus.MSD_CRC = sys_q;
  assign bus.p1_err  = p1_err_q;

endmodule
